// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and recovers its high time,
// period and duty in generator units, flagging inputs stuck at either level.
module pwm_capture #(
    parameter int CNT_W   = 8,
    parameter int MEAS_W  = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  duty,
    output logic [MEAS_W-1:0] high_time,
    output logic [MEAS_W-1:0] period,
    output logic              valid,
    output logic              locked,
    output logic              stuck
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [MEAS_W-1:0] TIMEOUT_CNT = MEAS_W'(TIMEOUT);
    localparam logic [MEAS_W-1:0] NOMINAL_CNT = MEAS_W'(2 ** CNT_W);

    state_t            state;
    state_t            state_nxt;
    logic              s1;
    logic              s2;
    logic              s3;
    logic              rise;
    logic              level;
    logic              timeout;
    logic              latch_run;
    logic              stuck_act;
    logic [MEAS_W-1:0] per_cnt;
    logic [MEAS_W-1:0] hi_cnt;

    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
        return (&v) ? v : v + MEAS_W'(1);
    endfunction

    // Synchroniser: s1/s2 resolve metastability, s3 is s2 delayed for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign level   = s2;
    assign timeout = (per_cnt == TIMEOUT_CNT) && !rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise) state_nxt = FIRST;
            end
            FIRST, RUN: begin
                if (rise)         state_nxt = RUN;
                else if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        latch_run = (state == RUN) && rise;
        stuck_act = (state != IDLE) && timeout;
    end

    // The rise cycle is cycle 1 of the new period; counters rest at 0 while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= MEAS_W'(1);
            hi_cnt  <= MEAS_W'(1);
        end else if (state_nxt == IDLE) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            per_cnt <= sat_inc(per_cnt);
            if (level) hi_cnt <= sat_inc(hi_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty      <= '0;
            high_time <= '0;
            period    <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (latch_run) begin
                period    <= per_cnt;
                high_time <= hi_cnt;
                duty      <= hi_cnt[CNT_W-1:0];
                locked    <= (per_cnt == NOMINAL_CNT);
                stuck     <= 1'b0;
                valid     <= 1'b1;
            end else if (stuck_act) begin
                // A stuck-high input reports full scale rather than the saturated count
                period <= '0;
                locked <= 1'b0;
                stuck  <= 1'b1;
                valid  <= 1'b1;
                if (level) begin
                    high_time <= TIMEOUT_CNT;
                    duty      <= '1;
                end else begin
                    high_time <= '0;
                    duty      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle,
// plus literal expectations for each stimulus scenario.
module tb_pwm_capture;
    localparam int CNT_W   = 8;
    localparam int MEAS_W  = 10;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pwm_in = 1'b0;
    logic [CNT_W-1:0]  duty;
    logic [MEAS_W-1:0] high_time;
    logic [MEAS_W-1:0] period;
    logic              valid;
    logic              locked;
    logic              stuck;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_capture #(.CNT_W(CNT_W), .MEAS_W(MEAS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .duty(duty),
        .high_time(high_time), .period(period), .valid(valid),
        .locked(locked), .stuck(stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: rises and levels as seen two clocks late, periods and
    // high times from rise timestamps and a running count of high cycles.
    logic              exp_valid, exp_locked, exp_stuck;
    logic [CNT_W-1:0]  exp_duty;
    logic [MEAS_W-1:0] exp_high, exp_period;
    logic              lv_q[$];
    logic              cur_lv, prev_lv;
    int                cyc, last_rise, hsum, hsum_last, nrise, p, h;

    task automatic model_reset();
        lv_q = '{1'b0, 1'b0};
        prev_lv = 1'b0;
        cyc = 0; last_rise = 0; hsum = 0; hsum_last = 0; nrise = 0;
        exp_valid = 1'b0; exp_locked = 1'b0; exp_stuck = 1'b0;
        exp_duty = '0; exp_high = '0; exp_period = '0;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cur_lv = lv_q.pop_front();
                lv_q.push_back(pwm_in);
                exp_valid = 1'b0;
                if (cur_lv && !prev_lv) begin
                    if (nrise >= 2) begin
                        p = cyc - last_rise;
                        h = hsum - hsum_last;
                        exp_period = MEAS_W'(p);
                        exp_high   = MEAS_W'(h);
                        exp_duty   = CNT_W'(h);
                        exp_locked = (p == 2 ** CNT_W);
                        exp_stuck  = 1'b0;
                        exp_valid  = 1'b1;
                    end
                    nrise++;
                    last_rise = cyc;
                    hsum_last = hsum;
                end else if (nrise > 0 && (cyc - last_rise) == TIMEOUT) begin
                    exp_period = '0;
                    exp_locked = 1'b0;
                    exp_stuck  = 1'b1;
                    exp_valid  = 1'b1;
                    exp_high   = cur_lv ? MEAS_W'(TIMEOUT) : '0;
                    exp_duty   = cur_lv ? '1 : '0;
                    nrise = 0;
                end
                hsum += int'(cur_lv);
                prev_lv = cur_lv;
                cyc++;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("cmp_valid",     32'(valid),     32'(exp_valid));
                check("cmp_duty",      32'(duty),      32'(exp_duty));
                check("cmp_high_time", 32'(high_time), 32'(exp_high));
                check("cmp_period",    32'(period),    32'(exp_period));
                check("cmp_locked",    32'(locked),    32'(exp_locked));
                check("cmp_stuck",     32'(stuck),     32'(exp_stuck));
            end
        end
    end

    // Record what each valid strobe reported
    int               v_count = 0;
    logic [CNT_W-1:0] dq[$];
    logic             log_en = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && valid === 1'b1) begin
                v_count++;
                if (log_en) dq.push_back(duty);
            end
        end
    end

    task automatic drive(input int hi, input int per, input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                pwm_in = (c < hi);
            end
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int d, input int ht, input int per,
                                 input int lk, input int st);
        check({tag, "_duty"},      32'(duty),      32'(d));
        check({tag, "_high_time"}, 32'(high_time), 32'(ht));
        check({tag, "_period"},    32'(period),    32'(per));
        check({tag, "_locked"},    32'(locked),    32'(lk));
        check({tag, "_stuck"},     32'(stuck),     32'(st));
    endtask

    int vc0, n_mid, bad, step, per_r, hi_r;
    logic seen200;

    initial begin : stimulus
        #12;
        check_outputs("reset", 0, 0, 0, 0, 0);
        check("reset_valid", 32'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 50% duty at nominal period
        drive(128, 256, 6);
        settle();
        check("d128_valid_count", 32'(v_count), 4);
        check_outputs("d128", 128, 128, 256, 1, 0);

        // Extreme duties
        drive(1, 256, 4);
        settle();
        check_outputs("d1", 1, 1, 256, 1, 0);
        drive(255, 256, 4);
        settle();
        check_outputs("d255", 255, 255, 256, 1, 0);

        // Held low: one stuck report, then silence
        vc0 = v_count;
        hold(1'b0, 1100);
        settle();
        check("low_stuck_count", 32'(v_count - vc0), 1);
        check_outputs("low_stuck", 0, 0, 0, 0, 1);
        vc0 = v_count;
        hold(1'b0, 1100);
        settle();
        check("low_no_more_valids", 32'(v_count - vc0), 0);

        // Held high after running at 64, then released
        drive(64, 256, 4);
        vc0 = v_count;
        hold(1'b1, 1100);
        settle();
        check("high_valid_count", 32'(v_count - vc0), 2);
        check_outputs("high_stuck", 255, 1023, 0, 0, 1);
        drive(64, 256, 5);
        settle();
        check_outputs("release64", 64, 64, 256, 1, 0);

        // Duty step 50 -> 200 at a random cycle
        step = $urandom_range(600, 1400);
        for (int c = 0; c < 256 * 9; c++) begin
            @(negedge clk);
            if (c == 512) log_en = 1'b1;
            pwm_in = ((c % 256) < ((c < step) ? 50 : 200));
        end
        settle();
        log_en = 1'b0;
        n_mid = 0; bad = 0; seen200 = 1'b0;
        foreach (dq[i]) begin
            if (dq[i] == 8'd200) seen200 = 1'b1;
            else begin
                if (seen200) bad++;
                if (dq[i] != 8'd50) n_mid++;
            end
        end
        check("step_no_regress", 32'(bad), 0);
        check("step_intermediate_le1", 32'(n_mid <= 1), 1);
        check("step_final_duty", 32'(duty), 200);

        // Off-nominal period
        drive(100, 300, 5);
        settle();
        check_outputs("per300", 100, 100, 300, 0, 0);

        // Random periods and duties, model-checked
        for (int k = 0; k < 6; k++) begin
            per_r = $urandom_range(150, 600);
            hi_r  = $urandom_range(1, per_r - 1);
            drive(hi_r, per_r, 2);
        end

        // Reset pulsed mid-high-phase
        drive(128, 256, 3);
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            pwm_in = (c < 128);
            if (c == 44) rst_n = 1'b1;
            if (c == 40) begin
                check("pre_reset_duty", 32'(duty), 128);
                #3 rst_n = 1'b0;
                #1;
                check_outputs("async_reset", 0, 0, 0, 0, 0);
                check("async_reset_valid", 32'(valid), 0);
            end
        end
        vc0 = v_count;
        drive(128, 256, 1);
        settle();
        check("post_reset_no_partial", 32'(v_count - vc0), 0);
        drive(128, 256, 2);
        settle();
        check("post_reset_valids", 32'(v_count - vc0), 2);
        check_outputs("post_reset", 128, 128, 256, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
